// File: rtl/interval_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer_ctrl_if
// Description : Control/status bundle for interval_timer_ctrl.
//               master : drives start/abort/pause and the run configuration
//                        (load_val, prescale, periodic); observes status.
//               slave  : the timer itself; observes control/configuration and
//                        drives count, state, busy, tick, done, cfg_err.
// Revision    : 1.0 - initial release
// ============================================================================
interface interval_timer_ctrl_if #(
    parameter int WIDTH    = 4,
    parameter int PS_WIDTH = 4
);
    logic                start;
    logic                abort;
    logic                pause;
    logic [WIDTH-1:0]    load_val;
    logic [PS_WIDTH-1:0] prescale;
    logic                periodic;

    logic [WIDTH-1:0]    count;
    logic [1:0]          state;
    logic                busy;
    logic                tick;
    logic                done;
    logic                cfg_err;

    modport master (
        output start, abort, pause, load_val, prescale, periodic,
        input  count, state, busy, tick, done, cfg_err
    );

    modport slave (
        input  start, abort, pause, load_val, prescale, periodic,
        output count, state, busy, tick, done, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer_ctrl
// Description : Programmable interval timer. A start latches the terminal
//               value, prescale divider and mode, then counts 0..term-1 once
//               every prescale+1 clocks, pulsing tick on each wrap. One-shot
//               runs park in DONE after the first wrap; periodic runs reload.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - interval_timer_ctrl_if.slave (control in, status out)
// Revision    : 1.0 - initial release
// ============================================================================
module interval_timer_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PS_WIDTH = 4
) (
    input  wire                    clk,
    input  wire                    rst,
    interval_timer_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    term_q, term_d;
    logic [PS_WIDTH-1:0] ps_cnt_q, ps_cnt_d;
    logic [PS_WIDTH-1:0] ps_q, ps_d;
    logic                mode_q, mode_d;
    logic                tick_q, tick_d;
    logic                cfg_err_q, cfg_err_d;
    logic                advance;
    logic [WIDTH-1:0]    term_last;

    assign term_last = term_q - WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            term_q    <= '0;
            ps_cnt_q  <= '0;
            ps_q      <= '0;
            mode_q    <= 1'b0;
            tick_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            term_q    <= term_d;
            ps_cnt_q  <= ps_cnt_d;
            ps_q      <= ps_d;
            mode_q    <= mode_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        term_d    = term_q;
        ps_cnt_d  = ps_cnt_q;
        ps_d      = ps_q;
        mode_d    = mode_q;
        tick_d    = 1'b0;
        cfg_err_d = 1'b0;
        advance   = 1'b0;

        if (bus.abort) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            ps_cnt_d = '0;
        end else if (bus.start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
            if (bus.load_val != '0) begin
                term_d   = bus.load_val;
                ps_d     = bus.prescale;
                mode_d   = bus.periodic;
                count_d  = '0;
                ps_cnt_d = '0;
                state_d  = ST_RUN;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else begin
            // A start seen in RUN/HOLD lands here and is simply ignored.
            case (state_q)
                ST_RUN: begin
                    if (bus.pause) state_d = ST_HOLD;
                    else           advance = 1'b1;
                end
                ST_HOLD: begin
                    // The release edge counts, so the run is delayed by
                    // exactly the number of edges pause was sampled high.
                    if (!bus.pause) begin
                        state_d = ST_RUN;
                        advance = 1'b1;
                    end
                end
                default: ;
            endcase

            if (advance) begin
                if (ps_cnt_q == ps_q) begin
                    ps_cnt_d = '0;
                    if (count_q == term_last) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                        if (!mode_q) state_d = ST_DONE;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    ps_cnt_d = ps_cnt_q + PS_WIDTH'(1);
                end
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.state   = state_q;
    assign bus.busy    = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.tick    = tick_q;
    assign bus.cfg_err = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_interval_timer_ctrl
// Description : Self-checking bench for interval_timer_ctrl. Each scenario
//               pushes its expected per-cycle status words into a scoreboard
//               queue and pops/compares them as the DUT advances.
//               Status word = {state[1:0], count[3:0], busy, tick, done, cfg_err}
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_timer_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [9:0] sb[$];
    logic [9:0] exp_w;

    interval_timer_ctrl_if #(.WIDTH(4), .PS_WIDTH(4)) bus ();

    interval_timer_ctrl #(.WIDTH(4), .PS_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] mk(input logic [1:0] st, input logic [3:0] cnt,
                                      input logic tk, input logic ce);
        return {st, cnt, (st == 2'd1 || st == 2'd2), tk, (st == 2'd3), ce};
    endfunction

    function automatic logic [9:0] obs();
        return {bus.state, bus.count, bus.busy, bus.tick, bus.done, bus.cfg_err};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(mk(2'd0, 4'd0, 1'b0, 1'b0));
        exp_w = sb.pop_front();
        checks++;
        if (obs() !== exp_w) begin
            failures++;
            $display("FAIL reset actual=%b expected=%b", obs(), exp_w);
        end
        rst = 1'b0;
    endtask

    // load 3, prescale 0, one-shot; configuration scribbled mid-run must not matter
    task automatic test_oneshot();
        sb.push_back(mk(2'd1, 4'd0, 1'b0, 1'b0));
        sb.push_back(mk(2'd1, 4'd1, 1'b0, 1'b0));
        sb.push_back(mk(2'd1, 4'd2, 1'b0, 1'b0));
        sb.push_back(mk(2'd3, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(2'd3, 4'd0, 1'b0, 1'b0));
        bus.start = 1'b1; bus.load_val = 4'd3; bus.prescale = 4'd0; bus.periodic = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.load_val = 4'd1; bus.periodic = 1'b1;
            exp_w = sb.pop_front();
            checks++;
            if (obs() !== exp_w) begin
                failures++;
                $display("FAIL oneshot k=%0d actual=%b expected=%b", k, obs(), exp_w);
            end
        end
    endtask

    // load 2, prescale 2, periodic: count steps every 3 clocks, tick every 6
    task automatic test_periodic();
        for (int k = 0; k <= 18; k++)
            sb.push_back(mk(2'd1, 4'((k / 3) % 2), (k > 0 && (k % 6) == 0), 1'b0));
        bus.start = 1'b1; bus.load_val = 4'd2; bus.prescale = 4'd2; bus.periodic = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0; bus.prescale = 4'd0; bus.load_val = 4'd9;
            exp_w = sb.pop_front();
            checks++;
            if (obs() !== exp_w) begin
                failures++;
                $display("FAIL periodic k=%0d actual=%b expected=%b", k, obs(), exp_w);
            end
        end
        sb.push_back(mk(2'd0, 4'd0, 1'b0, 1'b0));
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        exp_w = sb.pop_front();
        checks++;
        if (obs() !== exp_w) begin
            failures++;
            $display("FAIL periodic_abort actual=%b expected=%b", obs(), exp_w);
        end
    endtask

    // load 5 one-shot; pause high with start (ignored), then 4 edges at count 2
    task automatic test_pause();
        sb.push_back(mk(2'd1, 4'd0, 1'b0, 1'b0));
        sb.push_back(mk(2'd1, 4'd1, 1'b0, 1'b0));
        sb.push_back(mk(2'd1, 4'd2, 1'b0, 1'b0));
        for (int k = 3; k <= 6; k++) sb.push_back(mk(2'd2, 4'd2, 1'b0, 1'b0));
        sb.push_back(mk(2'd1, 4'd3, 1'b0, 1'b0));
        sb.push_back(mk(2'd1, 4'd4, 1'b0, 1'b0));
        sb.push_back(mk(2'd3, 4'd0, 1'b1, 1'b0));
        sb.push_back(mk(2'd3, 4'd0, 1'b0, 1'b0));
        bus.load_val = 4'd5; bus.prescale = 4'd0; bus.periodic = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            bus.start = (k == 0);
            bus.pause = (k == 0) || (k >= 3 && k <= 6);
            @(posedge clk); #1;
            exp_w = sb.pop_front();
            checks++;
            if (obs() !== exp_w) begin
                failures++;
                $display("FAIL pause k=%0d actual=%b expected=%b", k, obs(), exp_w);
            end
        end
        bus.pause = 1'b0;
    endtask

    // rejected start (load 0) in DONE and IDLE; start during RUN ignored
    task automatic test_reject();
        logic       s_start [10];
        logic       s_abort [10];
        logic [3:0] s_load  [10];
        logic [9:0] ex      [10];
        s_start = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        s_abort = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        s_load  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};
        ex = '{mk(2'd3, 4'd0, 1'b0, 1'b1), mk(2'd0, 4'd0, 1'b0, 1'b0),
               mk(2'd0, 4'd0, 1'b0, 1'b1), mk(2'd0, 4'd0, 1'b0, 1'b0),
               mk(2'd1, 4'd0, 1'b0, 1'b0), mk(2'd1, 4'd1, 1'b0, 1'b0),
               mk(2'd1, 4'd2, 1'b0, 1'b0), mk(2'd1, 4'd3, 1'b0, 1'b0),
               mk(2'd1, 4'd0, 1'b1, 1'b0), mk(2'd1, 4'd1, 1'b0, 1'b0)};
        bus.prescale = 4'd0; bus.periodic = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.start = s_start[k]; bus.abort = s_abort[k]; bus.load_val = s_load[k];
            sb.push_back(ex[k]);
            @(posedge clk); #1;
            exp_w = sb.pop_front();
            checks++;
            if (obs() !== exp_w) begin
                failures++;
                $display("FAIL reject k=%0d actual=%b expected=%b", k, obs(), exp_w);
            end
        end
        bus.start = 1'b0; bus.abort = 1'b0;
    endtask

    // start+abort in DONE, async reset mid-run, start on first edge after release
    task automatic test_simultaneous();
        logic       s_start [8];
        logic       s_abort [8];
        logic [3:0] s_load  [8];
        logic [9:0] ex      [8];
        s_start = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        s_abort = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        s_load  = '{4'd0, 4'd1, 4'd1, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
        ex = '{mk(2'd0, 4'd0, 1'b0, 1'b0), mk(2'd1, 4'd0, 1'b0, 1'b0),
               mk(2'd3, 4'd0, 1'b1, 1'b0), mk(2'd0, 4'd0, 1'b0, 1'b0),
               mk(2'd1, 4'd0, 1'b0, 1'b0), mk(2'd1, 4'd1, 1'b0, 1'b0),
               mk(2'd1, 4'd2, 1'b0, 1'b0), mk(2'd1, 4'd3, 1'b0, 1'b0)};
        bus.prescale = 4'd0; bus.periodic = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.start = s_start[k]; bus.abort = s_abort[k]; bus.load_val = s_load[k];
            sb.push_back(ex[k]);
            @(posedge clk); #1;
            exp_w = sb.pop_front();
            checks++;
            if (obs() !== exp_w) begin
                failures++;
                $display("FAIL simul k=%0d actual=%b expected=%b", k, obs(), exp_w);
            end
        end
        bus.start = 1'b0; bus.abort = 1'b0;
        // reset asserted between edges: outputs must clear without a clock
        #3 rst = 1'b1;
        sb.push_back(mk(2'd0, 4'd0, 1'b0, 1'b0));
        #1;
        exp_w = sb.pop_front();
        checks++;
        if (obs() !== exp_w) begin
            failures++;
            $display("FAIL rst_async actual=%b expected=%b", obs(), exp_w);
        end
        bus.start = 1'b1;
        sb.push_back(mk(2'd0, 4'd0, 1'b0, 1'b0));
        @(posedge clk); #1;
        exp_w = sb.pop_front();
        checks++;
        if (obs() !== exp_w) begin
            failures++;
            $display("FAIL rst_hold actual=%b expected=%b", obs(), exp_w);
        end
        rst = 1'b0;
        sb.push_back(mk(2'd1, 4'd0, 1'b0, 1'b0));
        sb.push_back(mk(2'd1, 4'd1, 1'b0, 1'b0));
        sb.push_back(mk(2'd1, 4'd2, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            exp_w = sb.pop_front();
            checks++;
            if (obs() !== exp_w) begin
                failures++;
                $display("FAIL post_rst k=%0d actual=%b expected=%b", k, obs(), exp_w);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.pause = 1'b0;
        bus.load_val = 4'd0; bus.prescale = 4'd0; bus.periodic = 1'b0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_reject();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/interval_timer_ctrl.md
INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, bit width of the count, terminal and load registers.
REQ-002 Parameter PS_WIDTH, default 4, bit width of the prescale register and prescale counter.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  sync request; arms a run using the load_val, prescale and periodic values sampled on the same edge.
REQ-006 abort  input  1  sync; cancels any activity and returns to IDLE.
REQ-007 pause  input  1  level; freezes a run while high.
REQ-008 load_val  input  WIDTH  terminal value; period = load_val count enables.
REQ-009 prescale  input  PS_WIDTH  divider; one count enable every prescale+1 clocks.
REQ-010 periodic  input  1  1 = auto-reload; 0 = one-shot.
REQ-011 count  output  WIDTH  current count value, registered.
REQ-012 state  output  2  encoding: IDLE=0, RUN=1, HOLD=2, DONE=3.
REQ-013 busy  output  1  high in RUN or HOLD.
REQ-014 tick  output  1  one-cycle pulse on each terminal wrap.
REQ-015 done  output  1  level; high in DONE.
REQ-016 cfg_err  output  1  one-cycle pulse when start is rejected.

Function
REQ-017 Input priority SHALL be: abort, then start, then pause, then count enable.
REQ-018 abort in any state SHALL cause, on the next edge: state IDLE, count 0, prescale counter 0, tick 0, cfg_err 0.
REQ-019 start in IDLE or DONE with load_val != 0 SHALL latch term=load_val, ps=prescale and mode=periodic, clear count and the prescale counter, and enter RUN; count=0 and busy=1 are visible in the next cycle.
REQ-020 start in IDLE or DONE with load_val == 0 SHALL leave the state unchanged and pulse cfg_err for one cycle.
REQ-021 start in RUN or HOLD SHALL be ignored, with no cfg_err pulse.
REQ-022 In RUN the prescale counter SHALL increment every clock; when it equals ps it SHALL return to 0 and generate one count enable in that cycle.
REQ-023 On a count enable with count < term-1, count SHALL increment by 1.
REQ-024 On a count enable with count == term-1, count SHALL wrap to 0 and tick SHALL be registered high for exactly the next cycle.
REQ-025 At the wrap in REQ-024: if mode=1, the state SHALL remain RUN; if mode=0, the state SHALL move to DONE.
REQ-026 pause=1 in RUN SHALL enter HOLD on the edge; no enable or increment SHALL occur on that edge.
REQ-027 In HOLD, count and the prescale counter SHALL be frozen; pause=0 SHALL return to RUN, and counting SHALL resume from the frozen values.
REQ-028 A start that enters RUN SHALL ignore pause on that edge; pause SHALL be evaluated from the following edge.
REQ-029 DONE SHALL hold count=0 and done=1 until start (which restarts per REQ-019 and REQ-020) or abort.
REQ-030 Changes to load_val, prescale or periodic during RUN or HOLD SHALL have no effect.
REQ-031 All outputs SHALL be registered or decoded directly from registered state; there SHALL be no combinational input-to-output paths.

Reset
REQ-032 While rst=1, and immediately on its assertion, the block SHALL hold: state IDLE, count 0, prescale counter 0, term 0, ps 0, mode 0, and busy, tick, done, cfg_err all 0.
REQ-033 Assertion of rst mid-run SHALL abandon the run without any tick pulse.
REQ-034 After rst is released, the block SHALL accept start on the first clock edge.

Verification
REQ-035 One-shot: start edge N, load_val=3, prescale=0, periodic=0 -> count 0,1,2 at N+1..N+3; count=0, tick=1 and done=1 at N+4; tick=0 at N+5.
REQ-036 Periodic with prescale: load_val=2, prescale=2, periodic=1 -> count changes every 3 clocks; tick every 6 clocks; busy stays 1 over 3 periods; abort -> state=IDLE and count=0 on the next cycle.
REQ-037 Pause: one-shot load_val=5, prescale=0; pause held for 4 cycles while count=2 -> state=HOLD and count=2 throughout; after release, tick arrives exactly 4 cycles later than in the unpaused run.
REQ-038 Rejected and ignored start: start with load_val=0 in IDLE -> cfg_err=1 for one cycle, state=IDLE; start during RUN -> count sequence undisturbed, no cfg_err.
REQ-039 Simultaneous events: start and abort on the same edge in DONE -> IDLE, done=0; rst pulse while count=3 -> all outputs 0 immediately, no tick; start on the first edge after release -> RUN.
